decode_control: RTL and testbench
=================================

DECODE_CONTROL -- requirements
Module: decode_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named as in the codebase.
REQ-002 Ports SHALL be:
  Clk  in  1  system clock, all state on rising edge
  Reset  in  1  asynchronous, active-high reset
  Instr  in  4  opcode nibble from fetch register
  Oprnd  in  4  operand nibble from fetch register
  Datos_Rom  in  8  current ROM output at PC
  C_flag  in  1  carry flag from datapath
  Z_flag  in  1  zero flag from datapath
  Enable_Fetch  out  1  fetch register load enable
  Enable_PCounter  out  1  program counter increment enable
  Activacion_PCounter_Load  out  1  program counter parallel load
  Load_PCounter  out  12  jump target for program counter
  Enable_Acc  out  1  accumulator write enable
  Enable_Flags  out  1  C/Z flag register write enable
  Alu_Sel  out  3  ALU function select
  Enable_Out  out  1  output port write enable
  Halted  out  1  processor stopped

Function
REQ-003 SHALL be a Moore FSM with states S_FETCH, S_EXEC, S_LOAD, S_HALT; all outputs SHALL decode from registered state and registers, except S_EXEC outputs, which SHALL also decode Instr, C_flag and Z_flag.
REQ-004 S_FETCH SHALL assert Enable_Fetch=1 and Enable_PCounter=1 for one cycle; all other outputs SHALL be 0; the next state SHALL be S_EXEC.
REQ-005 In S_EXEC, Instr/Oprnd SHALL hold the byte fetched in S_FETCH; Enable_Fetch SHALL be 0.
REQ-006 Opcode table in S_EXEC (one cycle, next state S_FETCH unless stated):
  0x0 NOP: no enables.
  0x1 LDI: Enable_Acc=1, Alu_Sel=000.
  0x2 ADDI: Enable_Acc=1, Enable_Flags=1, Alu_Sel=001.
  0x3 SUBI: Enable_Acc=1, Enable_Flags=1, Alu_Sel=010.
  0x4 ANDI: Enable_Acc=1, Enable_Flags=1, Alu_Sel=011.
  0x5 ORI: Enable_Acc=1, Enable_Flags=1, Alu_Sel=100.
  0x6 CMPI: Enable_Flags=1, Alu_Sel=010, Enable_Acc=0.
  0x7 OUT: Enable_Out=1.
  0xD, 0xE reserved: same as NOP.
  0xF HLT: no enables; next state S_HALT.
REQ-007 Opcodes 0x8 JMP, 0x9 JC, 0xA JNC, 0xB JZ and 0xC JNZ SHALL be two-byte instructions: target[11:8]=Oprnd and target[7:0]=second byte.
REQ-008 For a jump in S_EXEC:
  Datos_Rom (the second byte) SHALL be latched into addr_lo.
  Oprnd SHALL be latched into addr_hi.
  Enable_PCounter SHALL be 1 so the PC skips the second byte.
  Conditions: JMP always; JC if C_flag=1; JNC if C_flag=0; JZ if Z_flag=1; JNZ if Z_flag=0.
  Taken -> next state S_LOAD; not taken -> next state S_FETCH.
REQ-009 S_LOAD SHALL assert Activacion_PCounter_Load=1 with Load_PCounter={addr_hi,addr_lo} for one cycle; all other enables SHALL be 0; the next state SHALL be S_FETCH.
REQ-010 Outside S_LOAD, Load_PCounter SHALL hold its last registered value; Activacion_PCounter_Load SHALL be 0.
REQ-011 S_HALT SHALL drive Halted=1 and all enables 0, and SHALL remain in S_HALT until Reset.
REQ-012 Latency SHALL be: 1-byte instruction 2 cycles; not-taken jump 2 cycles; taken jump 3 cycles.
REQ-013 Enable_Fetch and Activacion_PCounter_Load SHALL never be 1 in the same cycle, nor Enable_PCounter and Activacion_PCounter_Load.
REQ-014 PC wrap (second byte at 0x000 after 0xFFF) SHALL need no special handling; addr_lo is whatever Datos_Rom presents.

Reset
REQ-015 While Reset=1, the state SHALL be S_FETCH and all outputs SHALL be 0, including Load_PCounter=0x000, addr_hi/addr_lo=0 and Halted=0.
REQ-016 Reset SHALL take effect immediately, without waiting for a clock edge, and SHALL override every state.
REQ-017 Reset asserted in S_EXEC or S_LOAD SHALL abort the instruction; no PC load SHALL occur.
REQ-018 The first rising edge after Reset deasserts SHALL perform S_FETCH, so fetch starts at PC=0x000.

Verification
REQ-019 Reset release, ROM[0]=0x15 (LDI 5) -> edge 1: Enable_Fetch=1 and Enable_PCounter=1; edge 2: Enable_Acc=1, Alu_Sel=000, Enable_Flags=0.
REQ-020 ROM[0..1]=0x83,0x4A (JMP 0x34A) -> S_EXEC: Enable_PCounter=1; S_LOAD: Activacion_PCounter_Load=1, Load_PCounter=0x34A; next fetch at 0x34A; 3 cycles total.
REQ-021 JZ 0x120 with Z_flag=0 -> no load pulse; next fetch at jump address+2. Repeat with Z_flag=1 -> Load_PCounter=0x120.
REQ-022 Each of JC, JNC and JNZ SHALL be run with its flag at 0 and at 1 -> taken/not-taken exactly per REQ-008.
REQ-023 0xF0 (HLT) -> Halted=1 with all enables 0 for 20 cycles; Reset -> Halted=0 and fetch restarts at 0x000.
REQ-024 Reset pulsed between edges while in S_LOAD -> outputs go to 0 immediately, with no Activacion_PCounter_Load pulse; after release, S_FETCH; protocol checker confirms REQ-013 on every cycle.

Source files
------------

// File: rtl/decode_control_if.sv
// decode_control_if
// Bundles the signals between the instruction decoder and the rest of the
// processor (fetch register, program counter, ROM, accumulator/ALU, flags).
//   master : the decoder side; samples opcode, operand, ROM byte and flags,
//            drives every enable, the ALU select, the PC jump target and Halted.
//   slave  : the datapath side; the mirror image of master.
// Clock and reset are not part of the bundle and stay plain module ports.
interface decode_control_if;
   logic [3:0]  Instr;
   logic [3:0]  Oprnd;
   logic [7:0]  Datos_Rom;
   logic        C_flag;
   logic        Z_flag;
   logic        Enable_Fetch;
   logic        Enable_PCounter;
   logic        Activacion_PCounter_Load;
   logic [11:0] Load_PCounter;
   logic        Enable_Acc;
   logic        Enable_Flags;
   logic [2:0]  Alu_Sel;
   logic        Enable_Out;
   logic        Halted;

   modport master (
      input  Instr, Oprnd, Datos_Rom, C_flag, Z_flag,
      output Enable_Fetch, Enable_PCounter, Activacion_PCounter_Load,
             Load_PCounter, Enable_Acc, Enable_Flags, Alu_Sel,
             Enable_Out, Halted
   );

   modport slave (
      output Instr, Oprnd, Datos_Rom, C_flag, Z_flag,
      input  Enable_Fetch, Enable_PCounter, Activacion_PCounter_Load,
             Load_PCounter, Enable_Acc, Enable_Flags, Alu_Sel,
             Enable_Out, Halted
   );
endinterface

// File: rtl/decode_control.sv
// decode_control
// Control unit of a small 4-bit-opcode processor. A four-state FSM sequences
// fetch, execute, PC load (taken jumps) and halt.
// Ports:
//   Clk   : system clock, all state changes on the rising edge
//   Reset : asynchronous, active-high; forces S_FETCH and drives all outputs 0
//   bus   : decode_control_if.master
//           inputs  Instr/Oprnd (fetch register), Datos_Rom (ROM byte at PC),
//                   C_flag/Z_flag (datapath flags)
//           outputs fetch/PC/accumulator/flag/output enables, ALU select,
//                   PC load pulse with its 12-bit target, Halted
// One-byte instructions take 2 cycles, not-taken jumps 2, taken jumps 3.
module decode_control (
   input  logic         Clk,
   input  logic         Reset,
   decode_control_if.master bus
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_LOAD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  addr_hi_q, addr_hi_d;
   logic [7:0]  addr_lo_q, addr_lo_d;
   logic [11:0] load_pc_q, load_pc_d;

   logic        jump_op;
   logic        jump_taken;

   logic        en_fetch;
   logic        en_pc;
   logic        pc_load;
   logic        en_acc;
   logic        en_flags;
   logic [2:0]  alu_sel;
   logic        en_out;
   logic        halted;

   // Jump opcodes 0x8..0xC and whether their condition holds for the flags
   // presented during execute. Only meaningful while in S_EXEC.
   always_comb begin
      jump_op    = 1'b0;
      jump_taken = 1'b0;
      case (bus.Instr)
         4'h8: begin jump_op = 1'b1; jump_taken = 1'b1;           end
         4'h9: begin jump_op = 1'b1; jump_taken = bus.C_flag;     end
         4'hA: begin jump_op = 1'b1; jump_taken = ~bus.C_flag;    end
         4'hB: begin jump_op = 1'b1; jump_taken = bus.Z_flag;     end
         4'hC: begin jump_op = 1'b1; jump_taken = ~bus.Z_flag;    end
         default: begin jump_op = 1'b0; jump_taken = 1'b0;        end
      endcase
   end

   // Next-state logic. During execute of any jump the second instruction byte
   // is already on the ROM output (PC advanced in fetch), so the target halves
   // are captured then. The visible jump target only changes for a taken jump,
   // so Load_PCounter keeps its previous value across not-taken jumps.
   always_comb begin
      state_d   = state_q;
      addr_hi_d = addr_hi_q;
      addr_lo_d = addr_lo_q;
      load_pc_d = load_pc_q;
      case (state_q)
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            if (jump_op) begin
               addr_hi_d = bus.Oprnd;
               addr_lo_d = bus.Datos_Rom;
               if (jump_taken) begin
                  load_pc_d = {bus.Oprnd, bus.Datos_Rom};
                  state_d   = S_LOAD;
               end else begin
                  state_d   = S_FETCH;
               end
            end else if (bus.Instr == 4'hF) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_LOAD:  state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // State and jump-target registers. Reset clears everything at once, which
   // also discards any jump that was half way through execute or load.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_FETCH;
         addr_hi_q <= 4'h0;
         addr_lo_q <= 8'h00;
         load_pc_q <= 12'h000;
      end else begin
         state_q   <= state_d;
         addr_hi_q <= addr_hi_d;
         addr_lo_q <= addr_lo_d;
         load_pc_q <= load_pc_d;
      end
   end

   // Output decode. Reset parks the FSM in S_FETCH, whose outputs are not all
   // zero, so every enable is also gated by Reset to keep outputs quiet while
   // it is held. Execute is the only state that looks at the opcode and flags.
   // Jumps bump the PC in execute so it steps past the second byte; a taken
   // jump then overwrites it in S_LOAD, where no other PC control is active.
   always_comb begin
      en_fetch = 1'b0;
      en_pc    = 1'b0;
      pc_load  = 1'b0;
      en_acc   = 1'b0;
      en_flags = 1'b0;
      alu_sel  = 3'b000;
      en_out   = 1'b0;
      halted   = 1'b0;
      if (!Reset) begin
         case (state_q)
            S_FETCH: begin
               en_fetch = 1'b1;
               en_pc    = 1'b1;
            end
            S_EXEC: begin
               case (bus.Instr)
                  4'h1: begin en_acc = 1'b1; alu_sel = 3'b000; end
                  4'h2: begin en_acc = 1'b1; en_flags = 1'b1; alu_sel = 3'b001; end
                  4'h3: begin en_acc = 1'b1; en_flags = 1'b1; alu_sel = 3'b010; end
                  4'h4: begin en_acc = 1'b1; en_flags = 1'b1; alu_sel = 3'b011; end
                  4'h5: begin en_acc = 1'b1; en_flags = 1'b1; alu_sel = 3'b100; end
                  4'h6: begin en_flags = 1'b1; alu_sel = 3'b010; end
                  4'h7: en_out = 1'b1;
                  4'h8, 4'h9, 4'hA, 4'hB, 4'hC: en_pc = 1'b1;
                  default: en_out = 1'b0;
               endcase
            end
            S_LOAD:  pc_load = 1'b1;
            S_HALT:  halted  = 1'b1;
            default: halted  = 1'b0;
         endcase
      end
   end

   assign bus.Enable_Fetch             = en_fetch;
   assign bus.Enable_PCounter          = en_pc;
   assign bus.Activacion_PCounter_Load = pc_load;
   assign bus.Load_PCounter            = load_pc_q;
   assign bus.Enable_Acc               = en_acc;
   assign bus.Enable_Flags             = en_flags;
   assign bus.Alu_Sel                  = alu_sel;
   assign bus.Enable_Out               = en_out;
   assign bus.Halted                   = halted;

endmodule

// File: tb/tb_decode_control.sv
// tb_decode_control
// Bench for decode_control. Surrounds the decoder with a ROM, a program
// counter and a fetch register so it runs real programs, then checks:
//   - a table of single instructions (every opcode, every jump flag case),
//   - hand-written halt and reset-during-load sequences,
//   - random programs against an instruction-level model that predicts the
//     per-cycle control outputs and where each fetch happens.
module tb_decode_control;

   logic Clk;
   logic Reset;

   decode_control_if bus ();

   decode_control dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   // Clock generation, 10 time-unit period.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Surrounding datapath: ROM, PC and fetch register driven by the decoder.
   logic [7:0]  rom [4096];
   logic [11:0] pc;
   logic [7:0]  fetch_q;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc      <= 12'h000;
         fetch_q <= 8'h00;
      end else begin
         if (bus.Activacion_PCounter_Load)
            pc <= bus.Load_PCounter;
         else if (bus.Enable_PCounter)
            pc <= pc + 12'd1;
         if (bus.Enable_Fetch)
            fetch_q <= rom[pc];
      end
   end

   assign bus.Instr     = fetch_q[7:4];
   assign bus.Oprnd     = fetch_q[3:0];
   assign bus.Datos_Rom = rom[pc];

   // Packed view of every output: {ef, epc, apl, lpc[11:0], acc, flg, alu[2:0], out, halt}
   logic [21:0] act;
   assign act = {bus.Enable_Fetch, bus.Enable_PCounter, bus.Activacion_PCounter_Load,
                 bus.Load_PCounter, bus.Enable_Acc, bus.Enable_Flags, bus.Alu_Sel,
                 bus.Enable_Out, bus.Halted};

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [21:0] mk(input logic ef, input logic epc, input logic apl,
                                      input logic [11:0] lpc, input logic acc,
                                      input logic flg, input logic [2:0] alu,
                                      input logic out, input logic halt);
      return {ef, epc, apl, lpc, acc, flg, alu, out, halt};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      n_checks++;
      if (actual !== required) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, actual, required, $time);
      end
   endtask

   // Instruction-level reference model: walks the program one instruction at
   // a time and queues the expected outputs of every cycle it will take.
   typedef struct {
      logic [21:0] vec;
      logic        chk_pc;
      logic [11:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] m_pc;
   logic [11:0] m_last;
   logic        m_halted;
   int          m_halt_cnt;

   task automatic model_reset();
      exp_q.delete();
      m_pc       = 12'h000;
      m_last     = 12'h000;
      m_halted   = 1'b0;
      m_halt_cnt = 0;
   endtask

   task automatic gen_instr();
      exp_t        e;
      logic [7:0]  b;
      logic [7:0]  b2;
      logic [3:0]  op;
      logic        taken;
      logic        acc;
      logic        flg;
      logic [2:0]  alu;
      logic        out;
      if (m_halted) begin
         e.vec = mk(0, 0, 0, m_last, 0, 0, 3'b000, 0, 1); e.chk_pc = 1'b0; e.pc = 12'h0;
         exp_q.push_back(e);
         m_halt_cnt++;
         return;
      end
      b  = rom[m_pc];
      op = b[7:4];
      bus.C_flag = 1'($urandom);
      bus.Z_flag = 1'($urandom);
      e.vec = mk(1, 1, 0, m_last, 0, 0, 3'b000, 0, 0); e.chk_pc = 1'b1; e.pc = m_pc;
      exp_q.push_back(e);
      e.chk_pc = 1'b0;
      if (op >= 4'h8 && op <= 4'hC) begin
         b2 = rom[m_pc + 12'd1];
         case (op)
            4'h8:    taken = 1'b1;
            4'h9:    taken = bus.C_flag;
            4'hA:    taken = !bus.C_flag;
            4'hB:    taken = bus.Z_flag;
            default: taken = !bus.Z_flag;
         endcase
         e.vec = mk(0, 1, 0, m_last, 0, 0, 3'b000, 0, 0);
         exp_q.push_back(e);
         if (taken) begin
            m_last = {b[3:0], b2};
            e.vec  = mk(0, 0, 1, m_last, 0, 0, 3'b000, 0, 0);
            exp_q.push_back(e);
            m_pc = m_last;
         end else begin
            m_pc = m_pc + 12'd2;
         end
      end else begin
         acc = 1'b0; flg = 1'b0; alu = 3'b000; out = 1'b0;
         if (op == 4'h1) acc = 1'b1;
         if (op >= 4'h2 && op <= 4'h5) begin
            acc = 1'b1; flg = 1'b1; alu = 3'(op - 4'd1);
         end
         if (op == 4'h6) begin flg = 1'b1; alu = 3'b010; end
         if (op == 4'h7) out = 1'b1;
         if (op == 4'hF) m_halted = 1'b1;
         e.vec = mk(0, 0, 0, m_last, acc, flg, alu, out, 0);
         exp_q.push_back(e);
         m_pc = m_pc + 12'd1;
      end
   endtask

   // One cycle of model-driven checking; entered and left at a falling edge.
   task automatic step();
      exp_t e;
      if (exp_q.size() == 0) gen_instr();
      e = exp_q.pop_front();
      #1;
      checkOutput("model_cycle", 32'(act), 32'(e.vec));
      if (e.chk_pc) checkOutput("model_fetch_pc", 32'(pc), 32'(e.pc));
      @(negedge Clk);
   endtask

   // Reset pulse spanning one full cycle; checks outputs are all zero while
   // held and returns on the falling edge where reset was released.
   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      #1;
      checkOutput("reset_outputs", 32'(act), 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
   endtask

   // Protocol checker: the PC load pulse never coexists with fetch or increment.
   always @(negedge Clk) begin
      #3;
      if (!Reset) begin
         checkOutput("excl_fetch_load", 32'(bus.Enable_Fetch & bus.Activacion_PCounter_Load), 32'h0);
         checkOutput("excl_inc_load", 32'(bus.Enable_PCounter & bus.Activacion_PCounter_Load), 32'h0);
      end
   end

   typedef struct {
      string       name;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        c;
      logic        z;
      logic        epc;
      logic        acc;
      logic        flg;
      logic [2:0]  alu;
      logic        out;
      logic        taken;
      logic        hlt;
      logic [11:0] npc;
   } vec_t;

   vec_t vecs[22];

   // Runs one table entry from reset: fetch, execute, then the follow-on
   // cycle (load pulse, halt, or the next fetch at the expected address).
   task automatic applyStimulus(input vec_t v);
      logic [11:0] tgt;
      tgt    = {v.b0[3:0], v.b1};
      rom[0] = v.b0;
      rom[1] = v.b1;
      bus.C_flag = v.c;
      bus.Z_flag = v.z;
      do_reset();
      #1;
      checkOutput({v.name, "_fetch"}, 32'(act), 32'(mk(1, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
      @(negedge Clk); #1;
      checkOutput({v.name, "_exec"}, 32'(act),
                  32'(mk(0, v.epc, 0, 12'h0, v.acc, v.flg, v.alu, v.out, 0)));
      @(negedge Clk); #1;
      if (v.taken) begin
         checkOutput({v.name, "_load"}, 32'(act), 32'(mk(0, 0, 1, tgt, 0, 0, 3'b000, 0, 0)));
         @(negedge Clk); #1;
         checkOutput({v.name, "_next_fetch"}, 32'(act), 32'(mk(1, 1, 0, tgt, 0, 0, 3'b000, 0, 0)));
         checkOutput({v.name, "_next_pc"}, 32'(pc), 32'(tgt));
      end else if (v.hlt) begin
         checkOutput({v.name, "_halt"}, 32'(act), 32'(mk(0, 0, 0, 12'h0, 0, 0, 3'b000, 0, 1)));
      end else begin
         checkOutput({v.name, "_next_fetch"}, 32'(act), 32'(mk(1, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
         checkOutput({v.name, "_next_pc"}, 32'(pc), 32'(v.npc));
      end
      @(negedge Clk);
   endtask

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] b;
      //               name    b0     b1     c  z  epc acc flg alu     out tk hlt npc
      vecs[0]  = '{"NOP",   8'h00, 8'h00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 12'h1};
      vecs[1]  = '{"LDI",   8'h15, 8'h00, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 12'h1};
      vecs[2]  = '{"ADDI",  8'h23, 8'h00, 1, 1, 0, 1, 1, 3'b001, 0, 0, 0, 12'h1};
      vecs[3]  = '{"SUBI",  8'h31, 8'h00, 0, 1, 0, 1, 1, 3'b010, 0, 0, 0, 12'h1};
      vecs[4]  = '{"ANDI",  8'h4F, 8'h00, 1, 0, 0, 1, 1, 3'b011, 0, 0, 0, 12'h1};
      vecs[5]  = '{"ORI",   8'h52, 8'h00, 0, 0, 0, 1, 1, 3'b100, 0, 0, 0, 12'h1};
      vecs[6]  = '{"CMPI",  8'h69, 8'h00, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 12'h1};
      vecs[7]  = '{"OUT",   8'h70, 8'h00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 12'h1};
      vecs[8]  = '{"RSV_D", 8'hD0, 8'h00, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 12'h1};
      vecs[9]  = '{"RSV_E", 8'hE7, 8'h00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 12'h1};
      vecs[10] = '{"JMP",   8'h83, 8'h4A, 0, 0, 1, 0, 0, 3'b000, 0, 1, 0, 12'h0};
      vecs[11] = '{"JC_c0", 8'h91, 8'h22, 0, 1, 1, 0, 0, 3'b000, 0, 0, 0, 12'h2};
      vecs[12] = '{"JC_c1", 8'h91, 8'h22, 1, 0, 1, 0, 0, 3'b000, 0, 1, 0, 12'h0};
      vecs[13] = '{"JNC_c0",8'hA1, 8'h33, 0, 1, 1, 0, 0, 3'b000, 0, 1, 0, 12'h0};
      vecs[14] = '{"JNC_c1",8'hA1, 8'h33, 1, 0, 1, 0, 0, 3'b000, 0, 0, 0, 12'h2};
      vecs[15] = '{"JZ_z0", 8'hB1, 8'h20, 1, 0, 1, 0, 0, 3'b000, 0, 0, 0, 12'h2};
      vecs[16] = '{"JZ_z1", 8'hB1, 8'h20, 0, 1, 1, 0, 0, 3'b000, 0, 1, 0, 12'h0};
      vecs[17] = '{"JNZ_z0",8'hC5, 8'h55, 1, 0, 1, 0, 0, 3'b000, 0, 1, 0, 12'h0};
      vecs[18] = '{"JNZ_z1",8'hC5, 8'h55, 0, 1, 1, 0, 0, 3'b000, 0, 0, 0, 12'h2};
      vecs[19] = '{"JMP_ff",8'h8F, 8'hFE, 0, 0, 1, 0, 0, 3'b000, 0, 1, 0, 12'h0};
      vecs[20] = '{"HLT",   8'hF0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 12'h0};
      vecs[21] = '{"HLT_x", 8'hF7, 8'h00, 1, 1, 0, 0, 0, 3'b000, 0, 0, 1, 12'h0};

      Reset      = 1'b1;
      bus.C_flag = 1'b0;
      bus.Z_flag = 1'b0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      model_reset();

      $display("[TB] table vectors");
      for (int i = 0; i < 22; i++) applyStimulus(vecs[i]);

      // Halt must hold for at least 20 cycles with every enable low, and
      // a reset must release it and restart fetching at address 0.
      $display("[TB] halt sequence");
      rom[0] = 8'hF0;
      rom[1] = 8'h15;
      do_reset();
      #1;
      checkOutput("hlt_fetch", 32'(act), 32'(mk(1, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
      @(negedge Clk); #1;
      checkOutput("hlt_exec", 32'(act), 32'h0);
      for (int i = 0; i < 20; i++) begin
         bus.C_flag = 1'($urandom);
         bus.Z_flag = 1'($urandom);
         @(negedge Clk); #1;
         checkOutput("hlt_hold", 32'(act), 32'(mk(0, 0, 0, 12'h0, 0, 0, 3'b000, 0, 1)));
      end
      do_reset();
      #1;
      checkOutput("hlt_restart_fetch", 32'(act), 32'(mk(1, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
      checkOutput("hlt_restart_pc", 32'(pc), 32'h0);
      @(negedge Clk);

      // Reset arriving mid-cycle while the load pulse is up must kill it at
      // once and leave the PC at 0 rather than the jump target.
      $display("[TB] reset during load");
      rom[0] = 8'h83;
      rom[1] = 8'h4A;
      do_reset();
      #1;
      checkOutput("rl_fetch", 32'(act), 32'(mk(1, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
      @(negedge Clk); #1;
      checkOutput("rl_exec", 32'(act), 32'(mk(0, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
      @(negedge Clk); #1;
      checkOutput("rl_load", 32'(act), 32'(mk(0, 0, 1, 12'h34A, 0, 0, 3'b000, 0, 0)));
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("rl_immediate_zero", 32'(act), 32'h0);
      @(posedge Clk); #1;
      checkOutput("rl_held_zero", 32'(act), 32'h0);
      checkOutput("rl_pc_not_loaded", 32'(pc), 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      #1;
      checkOutput("rl_after_fetch", 32'(act), 32'(mk(1, 1, 0, 12'h0, 0, 0, 3'b000, 0, 0)));
      checkOutput("rl_after_pc", 32'(pc), 32'h0);
      @(negedge Clk);

      // Random programs against the reference model; HLT is kept rare so
      // runs are long, and a halted program is restarted by reset.
      $display("[TB] random programs");
      for (int i = 0; i < 4096; i++) begin
         b = 8'($urandom);
         if (b[7:4] == 4'hF && $urandom_range(0, 15) != 0) b[7:4] = 4'h7;
         rom[i] = b;
      end
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (m_halted && m_halt_cnt >= 4 && exp_q.size() == 0) do_reset();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
